// File: rtl/bp_pkg.sv
// ============================================================================
// bp_pkg: shared types and defaults for the branch predictor update path.
// Revision 1.0
// ============================================================================
`default_nettype none

package bp_pkg;

   localparam int BP_PC_WIDTH  = 32;
   localparam int BP_DEPTH     = 4;
   localparam int BP_CNT_WIDTH = 16;

   // PCs narrower than BP_PC_WIDTH are stored zero-extended.
   typedef struct packed {
      logic [BP_PC_WIDTH-1:0] pc;
      logic                   pred;
   } bp_entry_t;

   localparam int BP_ENTRY_WIDTH = $bits(bp_entry_t);

endpackage

`default_nettype wire

// File: rtl/branch_fifo.sv
// ============================================================================
// branch_fifo: in-flight branch circular buffer with mispredict flush.
// Revision 1.0
// ============================================================================
`default_nettype none

module branch_fifo
   import bp_pkg::*;
#(
   parameter int depth = BP_DEPTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic [BP_ENTRY_WIDTH-1:0] push_entry,
   input  logic                      pop,
   input  logic                      flush,
   output logic [BP_ENTRY_WIDTH-1:0] head_entry,
   output logic [$clog2(depth):0]    count,
   output logic                      empty,
   output logic                      full
);

   localparam int PTR_W = $clog2(depth);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W:0]   OCC_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   OCC_MAX = (PTR_W+1)'(depth);

   logic [BP_ENTRY_WIDTH-1:0] mem [depth];
   logic [PTR_W-1:0]          wr_ptr;
   logic [PTR_W-1:0]          rd_ptr;
   logic [PTR_W:0]            occ;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else if (flush) begin
         // Flush accompanies the pop of the head; everything younger is dropped.
         rd_ptr <= rd_ptr + PTR_ONE;
         wr_ptr <= rd_ptr + PTR_ONE;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   occ <= occ + OCC_ONE;
            2'b01:   occ <= occ - OCC_ONE;
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_entry;
   end

   assign head_entry = mem[rd_ptr];
   assign count      = occ;
   assign empty      = (occ == '0);
   assign full       = (occ == OCC_MAX);

endmodule

`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
// ============================================================================
// branch_resolve_ctrl: in-order resolve sequencer driving the predictor update.
// Revision 1.0
// ============================================================================
`default_nettype none

module branch_resolve_ctrl
   import bp_pkg::*;
#(
   parameter int bit_width = BP_PC_WIDTH,
   parameter int depth     = BP_DEPTH,
   parameter int cnt_width = BP_CNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   issue_valid,
   input  logic [bit_width-1:0]   issue_pc,
   input  logic                   issue_pred,
   output logic                   issue_ready,
   input  logic                   resolve_valid,
   input  logic                   resolve_taken,
   output logic                   update,
   output logic [bit_width-1:0]   updatePc,
   output logic                   reality,
   output logic                   mispredict,
   output logic                   empty,
   output logic [$clog2(depth):0] count,
   output logic [cnt_width-1:0]   hit_count,
   output logic [cnt_width-1:0]   miss_count
);

   localparam logic [cnt_width-1:0] CNT_ONE = cnt_width'(1);
   localparam logic [cnt_width-1:0] CNT_MAX = '1;

   bp_entry_t                 issue_entry;
   bp_entry_t                 head_entry;
   logic [BP_ENTRY_WIDTH-1:0] head_bits;
   logic                      full;
   logic                      push;
   logic                      pop;
   logic                      miss_now;

   assign issue_entry.pc   = BP_PC_WIDTH'(issue_pc);
   assign issue_entry.pred = issue_pred;
   assign head_entry       = bp_entry_t'(head_bits);

   // Ready reflects occupancy before any same-cycle pop, so a full queue never pushes.
   assign issue_ready = !full;
   assign push        = issue_valid && issue_ready;
   assign pop         = resolve_valid && !empty;
   assign miss_now    = pop && (head_entry.pred != resolve_taken);

   branch_fifo #(
      .depth (depth)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (issue_entry),
      .pop        (pop),
      .flush      (miss_now),
      .head_entry (head_bits),
      .count      (count),
      .empty      (empty),
      .full       (full)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         update     <= 1'b0;
         updatePc   <= '0;
         reality    <= 1'b0;
         mispredict <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         update     <= pop;
         mispredict <= miss_now;
         if (pop) begin
            updatePc <= head_entry.pc[bit_width-1:0];
            reality  <= resolve_taken;
            if (miss_now) begin
               if (miss_count != CNT_MAX) miss_count <= miss_count + CNT_ONE;
            end else begin
               if (hit_count != CNT_MAX) hit_count <= hit_count + CNT_ONE;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
// ============================================================================
// tb_branch_resolve_ctrl: directed scoreboard bench for branch_resolve_ctrl.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolve_ctrl;

   localparam int BW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          issue_valid;
   logic [BW-1:0] issue_pc;
   logic          issue_pred;
   logic          issue_ready;
   logic          resolve_valid;
   logic          resolve_taken;
   logic          update;
   logic [BW-1:0] updatePc;
   logic          reality;
   logic          mispredict;
   logic          empty;
   logic [2:0]    count;
   logic [CW-1:0] hit_count;
   logic [CW-1:0] miss_count;

   always #5 clk = ~clk;

   branch_resolve_ctrl #(
      .bit_width (BW),
      .depth     (DEPTH),
      .cnt_width (CW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .issue_valid   (issue_valid),
      .issue_pc      (issue_pc),
      .issue_pred    (issue_pred),
      .issue_ready   (issue_ready),
      .resolve_valid (resolve_valid),
      .resolve_taken (resolve_taken),
      .update        (update),
      .updatePc      (updatePc),
      .reality       (reality),
      .mispredict    (mispredict),
      .empty         (empty),
      .count         (count),
      .hit_count     (hit_count),
      .miss_count    (miss_count)
   );

   typedef struct {
      logic [BW-1:0] pc;
      logic          pred;
   } ent_t;

   typedef struct {
      logic [BW-1:0] pc;
      logic          taken;
      logic          mis;
   } upd_t;

   ent_t model_q[$];
   upd_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   m_hit      = 0;
   int   m_miss     = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      issue_valid   = 1'b0;
      issue_pc      = '0;
      issue_pred    = 1'b0;
      resolve_valid = 1'b0;
      resolve_taken = 1'b0;
   endtask

   // One clock of stimulus; the model predicts, the DUT is checked after the edge.
   task automatic step(input logic iv, input logic [BW-1:0] ipc, input logic ip,
                       input logic rv, input logic rt);
      logic ready, push_ok, pop_ok, mis;
      ent_t h, e;
      upd_t u;
      issue_valid   = iv;
      issue_pc      = ipc;
      issue_pred    = ip;
      resolve_valid = rv;
      resolve_taken = rt;
      ready   = (model_q.size() != DEPTH);
      chk("issue_ready", issue_ready, ready);
      push_ok = iv && ready;
      pop_ok  = rv && (model_q.size() != 0);
      mis     = 1'b0;
      if (pop_ok) begin
         h       = model_q.pop_front();
         mis     = (h.pred != rt);
         u.pc    = h.pc;
         u.taken = rt;
         u.mis   = mis;
         exp_q.push_back(u);
         if (mis) begin
            if (m_miss != CMAX) m_miss++;
         end else begin
            if (m_hit != CMAX) m_hit++;
         end
      end
      if (mis) model_q.delete();
      else if (push_ok) begin
         e.pc   = ipc;
         e.pred = ip;
         model_q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         u = exp_q.pop_front();
         chk("update", update, 1'b1);
         chk("updatePc", updatePc, u.pc);
         chk("reality", reality, u.taken);
         chk("mispredict", mispredict, u.mis);
      end else begin
         chk("update_idle", update, 1'b0);
         chk("mispredict_idle", mispredict, 1'b0);
      end
      chk("count", count, model_q.size());
      chk("empty", empty, model_q.size() == 0);
      chk("hit_count", hit_count, m_hit);
      chk("miss_count", miss_count, m_miss);
   endtask

   task automatic do_reset(input logic rv);
      reset         = 1'b1;
      issue_valid   = 1'b1;
      issue_pc      = 32'hDEAD;
      issue_pred    = 1'b1;
      resolve_valid = rv;
      resolve_taken = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle();
      model_q.delete();
      exp_q.delete();
      m_hit  = 0;
      m_miss = 0;
      chk("rst_update", update, 1'b0);
      chk("rst_updatePc", updatePc, '0);
      chk("rst_reality", reality, 1'b0);
      chk("rst_mispredict", mispredict, 1'b0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1'b1);
      chk("rst_issue_ready", issue_ready, 1'b1);
      chk("rst_hit", hit_count, 0);
      chk("rst_miss", miss_count, 0);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      do_reset(1'b0);

      // Single correctly predicted branch.
      step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);

      // Fill to depth, overflow issue ignored, drain in order.
      step(1'b1, 32'h10, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h30, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h50, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);

      // Mispredict flushes younger entries and drops the concurrent issue.
      step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h20, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h30, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h40, 1'b1, 1'b1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);

      // Steady push+pop across pointer wrap; hit counter saturates.
      step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h204, 1'b1, 1'b0, 1'b0);
      for (int i = 2; i < 12; i++) begin
         step(1'b1, 32'h200 + 32'(i * 4), i[0], 1'b1, i[0]);
      end
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);

      // Resolve while empty is ignored.
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);

      // Reset with entries in flight and an update pulse pending.
      step(1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h304, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h308, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h30C, 1'b1, 1'b1, 1'b1);
      do_reset(1'b1);
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);

      // Miss counter saturation.
      for (int i = 0; i < CMAX + 2; i++) begin
         step(1'b1, 32'h400 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
         step(1'b0, '0, 1'b0, 1'b1, 1'b1);
      end

      idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
